// File: rtl/wb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants for the register-file writeback arbiter.
//                Select encodings for ctrlSlct and default port widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // ctrlSlct encodings: which requester owns the write port this cycle
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // Default widths of the writeback path
    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_slot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_slot
//  Description : One-entry holding slot for a writeback requester. Accepts a
//                new entry whenever it is empty or being drained this cycle,
//                so a draining slot can be refilled without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_slot
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              rdy
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Slot storage: a load wins over a clear, giving the pass-through refill
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (load) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (clear) begin
            r_full <= 1'b0;
        end
    end

    // Ready depends only on slot state and the drain decision, never on the request
    assign rdy    = !r_full || clear;
    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule : wb_slot
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the single register-file write port between the ALU
//                (slot 0) and memory-load (slot 1) writeback requesters.
//                Drains one slot per cycle: same-address conflicts resolve by
//                age to keep write order, otherwise round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              rdy0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              rdy1,
    input  logic              hold,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              ctrlSlct
);

    logic              w_full0, w_full1;
    logic [ADDR_W-1:0] w_addr0, w_addr1;
    logic [DATA_W-1:0] w_data0, w_data1;
    logic              w_load0, w_load1;
    logic              w_clear0, w_clear1;
    logic              w_drain;
    logic              w_sel;
    logic              r_rr_ptr;    // slot favoured when both are full with distinct addresses
    logic              r_age_bit;   // 1 = slot 1 holds the older entry

    assign w_load0  = req0 && rdy0;
    assign w_load1  = req1 && rdy1;
    assign w_clear0 = w_drain && (w_sel == SEL_ALU);
    assign w_clear1 = w_drain && (w_sel == SEL_MEM);

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
        .clk    (clk),
        .rstN   (rstN),
        .load   (w_load0),
        .clear  (w_clear0),
        .i_addr (addr0),
        .i_data (data0),
        .o_full (w_full0),
        .o_addr (w_addr0),
        .o_data (w_data0),
        .rdy    (rdy0)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
        .clk    (clk),
        .rstN   (rstN),
        .load   (w_load1),
        .clear  (w_clear1),
        .i_addr (addr1),
        .i_data (data1),
        .o_full (w_full1),
        .o_addr (w_addr1),
        .o_data (w_data1),
        .rdy    (rdy1)
    );

    // Drain selection: single full slot, else age on address match, else round-robin
    always_comb begin
        w_drain = !hold && (w_full0 || w_full1);
        w_sel   = SEL_ALU;
        if (w_full0 && !w_full1) begin
            w_sel = SEL_ALU;
        end else if (w_full1 && !w_full0) begin
            w_sel = SEL_MEM;
        end else if (w_addr0 == w_addr1) begin
            w_sel = r_age_bit;
        end else begin
            w_sel = r_rr_ptr;
        end
    end

    // Write-port muxing; idle outputs are forced to zero
    always_comb begin
        wrEn     = w_drain;
        wrAddr   = '0;
        wrData   = '0;
        ctrlSlct = SEL_ALU;
        if (w_drain) begin
            ctrlSlct = w_sel;
            wrAddr   = (w_sel == SEL_MEM) ? w_addr1 : w_addr0;
            wrData   = (w_sel == SEL_MEM) ? w_data1 : w_data0;
        end
    end

    // Round-robin pointer and relative age of the two slot entries
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_rr_ptr  <= 1'b0;
            r_age_bit <= 1'b0;
        end else begin
            if (w_drain) begin
                r_rr_ptr <= ~w_sel;
            end
            if (w_load0 && w_load1) begin
                r_age_bit <= 1'b0;
            end else if (w_load0 && w_full1 && !w_clear1) begin
                r_age_bit <= 1'b1;
            end else if (w_load1 && w_full0 && !w_clear0) begin
                r_age_bit <= 1'b0;
            end
        end
    end

endmodule : wb_port_arbiter
`default_nettype wire
